vram_write_ctrl: RTL

AXI4 write initiator that transfers one XGA frame (1024×768, 16 bpp) from a show-ahead pixel FIFO into VRAM in fixed 64-byte bursts. It sits between the capture/drawing pipeline and the HP port, and is the write-side counterpart of the display read controller. It shares the same VRAM window (0x10000000–0x1FFFFFFF) and the same frame size.

---
 rtl/vram_write_ctrl_pkg.sv | 16 +
 rtl/vram_write_ctrl_if.sv | 25 ++
 rtl/vram_write_ctrl_start_sync.sv | 18 +
 rtl/vram_write_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/vram_write_ctrl_pkg.sv
// Shared constants and state encoding for the VRAM write initiator.
// Also referenced by the display read controller (same window, same frame size).
package vram_pkg;
    localparam logic [27:0] FRAME_BYTES      = 28'd1572864;
    localparam logic [27:0] BURST_BYTES      = 28'd64;
    localparam logic [3:0]  VRAM_BASE_NIBBLE = 4'b0001;
    localparam logic [7:0]  AWLEN_FIXED      = 8'd15;

    typedef enum logic [2:0] {
        HALT,
        WAITFIFO,
        SETADDR,
        WRITING,
        WAITRESP
    } wr_state_e;
endpackage

// File: rtl/vram_write_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) between the write initiator and the HP port.
interface vram_write_ctrl_if;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/vram_write_ctrl_start_sync.sv
// 3-FF synchronizer for an asynchronous start level plus rising-edge detect.
// Shared with the read controller; rise is a one-cycle pulse.
module start_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[1:0], async_in};
    end

    // Edge is taken between the two settled stages, never the metastable one.
    assign rise = (sync[2:1] == 2'b01);
endmodule

// File: rtl/vram_write_ctrl.sv
// AXI4 write initiator: streams one frame from a show-ahead FIFO into VRAM in
// fixed 16-beat bursts. Optional macro VRAM_WR_BRESP_CHECK_EN enables BRESP error abort.
module vram_write_ctrl #(
    parameter logic [27:0] FRAME_BYTES = vram_pkg::FRAME_BYTES,
    parameter logic [27:0] BURST_BYTES = vram_pkg::BURST_BYTES
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    vram_write_ctrl_if.master        axi,
    input  logic                     WRSTART,
    input  logic [27:0]              WRADDR,
    input  logic [31:0]              FIFODATA,
    input  logic                     FIFOREADY,
    output logic                     FIFORD,
    output logic                     WRBUSY,
    output logic                     WRERR
);
    import vram_pkg::*;

    wr_state_e   state, state_nxt;
    logic [27:0] addrcnt;
    logic [3:0]  beatcnt;
    logic        wrstart;
    logic        bresp_err;
    logic        aw_valid, w_valid, b_ready;

    start_sync u_start_sync (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .async_in (WRSTART),
        .rise     (wrstart)
    );

`ifdef VRAM_WR_BRESP_CHECK_EN
    assign bresp_err = (axi.BRESP != 2'b00);
`else
    logic unused_bresp;
    assign unused_bresp = ^axi.BRESP;
    assign bresp_err    = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= HALT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HALT:     if (wrstart)   state_nxt = WAITFIFO;
            WAITFIFO: if (FIFOREADY) state_nxt = SETADDR;
            SETADDR:  if (axi.AWREADY) state_nxt = WRITING;
            WRITING:  if (axi.WREADY && beatcnt == 4'd15) state_nxt = WAITRESP;
            WAITRESP: begin
                if (axi.BVALID) begin
                    if (bresp_err)                    state_nxt = HALT;
                    else if (addrcnt == FRAME_BYTES)  state_nxt = HALT;
                    else if (!FIFOREADY)              state_nxt = WAITFIFO;
                    else                              state_nxt = SETADDR;
                end
            end
            default:  state_nxt = HALT;
        endcase
    end

    // Channel valids come straight from the registered state, so they never glitch.
    always_comb begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        case (state)
            SETADDR:  aw_valid = 1'b1;
            WRITING:  w_valid  = 1'b1;
            WAITRESP: b_ready  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                         addrcnt <= '0;
        else if (state == HALT && wrstart)    addrcnt <= '0;
        else if (aw_valid && axi.AWREADY)     addrcnt <= addrcnt + BURST_BYTES;
    end

    // Held at zero outside WRITING so every burst starts from beat 0.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                  beatcnt <= '0;
        else if (state != WRITING)     beatcnt <= '0;
        else if (axi.WREADY)           beatcnt <= beatcnt + 4'd1;
    end

`ifdef VRAM_WR_BRESP_CHECK_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                                           WRERR <= 1'b0;
        else if (state == HALT && wrstart)                      WRERR <= 1'b0;
        else if (state == WAITRESP && axi.BVALID && bresp_err)  WRERR <= 1'b1;
    end
`else
    assign WRERR = 1'b0;
`endif

    assign axi.AWADDR  = {VRAM_BASE_NIBBLE, addrcnt + WRADDR};
    assign axi.AWLEN   = AWLEN_FIXED;
    assign axi.AWVALID = aw_valid;
    assign axi.WDATA   = FIFODATA;
    assign axi.WSTRB   = 4'hF;
    assign axi.WVALID  = w_valid;
    assign axi.WLAST   = w_valid && (beatcnt == 4'd15);
    assign axi.BREADY  = b_ready;
    assign FIFORD      = w_valid && axi.WREADY;
    assign WRBUSY      = (state != HALT);
endmodule
